// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first unsigned subtractor: one difference bit per clock,
// with a start/busy/done handshake that allows back-to-back operations.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_load;
  logic w_last;
  logic w_busy;
  logic w_done;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_difference;
  logic             r_borrow;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A new operation is accepted whenever no computation is in flight,
  // which includes the single DONE cycle so operations can run back-to-back.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-bit subtract step: half-subtractor extended with the registered borrow.
  always_comb begin
    w_ai      = r_a_sh[0];
    w_bi      = r_b_sh[0];
    w_d       = w_ai ^ w_bi ^ r_br;
    w_br_nxt  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    w_res_nxt = {w_d, r_res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res_sh     <= '0;
      r_cnt        <= '0;
      r_br         <= 1'b0;
      r_difference <= '0;
      r_borrow     <= 1'b0;
    end else if (w_load) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_cnt  <= '0;
      r_br   <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_res_sh <= w_res_nxt;
      r_br     <= w_br_nxt;
      r_cnt    <= r_cnt + CNT_W'(1);
      // Outputs only ever see the complete word, never a partial result.
      if (w_last) begin
        r_difference <= w_res_nxt;
        r_borrow     <= w_br_nxt;
      end
    end
  end

  assign busy       = w_busy;
  assign done       = w_done;
  assign difference = r_difference;
  assign borrow_out = r_borrow;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first multi-bit subtractor that computes A − B one bit per clock.
- Each step applies the half-subtractor difference/borrow equations extended with a registered borrow-in.
- Sits next to the combinational half/full subtractor cells as the area-minimal sequential alternative.
- Uses a start/busy/done handshake so a controller or bench can issue back-to-back operations.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while bit-serial computation in progress.
- done  output  1  one-cycle pulse: difference/borrow_out just updated.
- difference  output  WIDTH  (a − b) mod 2^WIDTH of last completed operation.
- borrow_out  output  1  final borrow; 1 when a < b (unsigned).

Behaviour:
- Reset (rst=1 at a clk edge, synchronous, overrides everything including start):
  - state=IDLE; busy=0, done=0, difference=0, borrow_out=0.
  - Internal shift registers, bit counter and borrow flop cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0.
  - start=1 → latch a, b into shift regs; borrow flop=0; count=0; go to SHIFT.
- SHIFT: busy=1, done=0. Each edge processes bit 0 of the shift regs (ai, bi):
  - d = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - Operand regs shift right; d is shifted into the MSB of the internal result reg; count increments.
  - start is ignored; operand inputs are not re-sampled.
  - On the edge processing count=WIDTH−1: copy result reg → difference and br_next → borrow_out; go to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE → SHIFT (back-to-back).
  - Otherwise → IDLE.
- Latency: start sampled at edge N → busy=1 after edge N, through the cycle ending at edge N+WIDTH.
  - done=1 and new results are visible after edge N+WIDTH.
  - Throughput: one operation per WIDTH+1 cycles with back-to-back start.
- difference and borrow_out change only on entry to DONE (or on reset) and hold otherwise. Partial results are never visible on outputs.
- Arithmetic: unsigned modulo 2^WIDTH; borrow_out=1 iff a < b.
- Reset during SHIFT aborts the operation:
  - No done pulse.
  - Outputs cleared to 0, not restored to the previous result.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start 1 cycle → busy high 8 cycles, then done=1 for 1 cycle with difference=0x02, borrow_out=0.
- a=0x03, b=0x05 → difference=0xFE, borrow_out=1; a=0x00, b=0x01 → 0xFF, 1; a=0xFF, b=0xFF → 0x00, 0.
- Start a=0x10, b=0x01; in the 3rd busy cycle, drive start=1 with a=0x00, b=0xFF → ignored; result 0x0F, borrow_out=0, exactly one done pulse.
- Start a=0x80, b=0x01 and complete (0x7F, 0); start again, assert rst in the 4th busy cycle → next cycle busy=0, difference=0x00, borrow_out=0, no done.
- Assert start with new operands in the done cycle (a=0x20, b=0x21) → SHIFT entered with no idle gap; next done exactly 9 cycles later with 0xFF, borrow_out=1.
- WIDTH=2 exhaustive: all 16 (a,b) pairs sequentially → difference=(a−b) mod 4 and borrow_out=(a<b) each time; printed a, b, difference, borrow_out match the model.
